// File: rtl/vga_fill_engine_pkg.sv
// Shared constants, state encoding and helpers for the VGA rectangle fill engine.
package vga_fill_pkg;

  // Register offsets inside the VGA peripheral window.
  localparam logic [7:0] REG_EN       = 8'h00;
  localparam logic [7:0] REG_X_ADDR   = 8'h04;
  localparam logic [7:0] REG_Y_ADDR   = 8'h08;
  localparam logic [7:0] REG_DATA     = 8'h0C;
  localparam logic [7:0] REG_SCANLINE = 8'h1C;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POLL  = 3'd1,
    SET_X = 3'd2,
    SET_Y = 3'd3,
    FILL  = 3'd4,
    DONE  = 3'd5
  } fill_state_e;

  // Length clipped so that pos+len never runs past lim; caller guarantees pos < lim.
  function automatic logic [11:0] clip_len(input logic [11:0] pos,
                                           input logic [11:0] len,
                                           input logic [11:0] lim);
    logic [11:0] room;
    room = lim - pos;
    return (len < room) ? len : room;
  endfunction

endpackage

// File: rtl/vga_fill_engine_if.sv
// Simple worker memory bus between the fill engine (master) and the VGA peripheral (slave).
interface vga_fill_engine_if;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_byteEn;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_addr;
  logic [3:0]  rd_byteEn;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;

  modport master (
    output wr_addr, wr_data, wr_byteEn, wr_valid, rd_addr, rd_byteEn, rd_valid,
    input  wr_ready, rd_ready, rd_data
  );

  modport slave (
    input  wr_addr, wr_data, wr_byteEn, wr_valid, rd_addr, rd_byteEn, rd_valid,
    output wr_ready, rd_ready, rd_data
  );
endinterface

// File: rtl/vga_fill_engine_bus_req.sv
// Single-transaction bus requester: holds one read or write until the worker
// answers with ready, or gives up after TIMEOUT cycles.
module vga_bus_req #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_i,
  input  logic              is_rd_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  output logic              busy_o,
  output logic              ack_o,
  output logic              timeout_o,
  output logic              line_zero_o,
  vga_fill_engine_if.master bus
);

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

  logic        req_q;
  logic        rd_q;
  logic        seen_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [15:0] cnt_q;
  logic        ready_sel;
  logic        drive_valid;
  logic        unused_rd_bits;

  // Valid is masked in any cycle the worker shows ready, so it never samples
  // a request in the same cycle it is completing one.
  assign ready_sel   = rd_q ? bus.rd_ready : bus.wr_ready;
  assign drive_valid = req_q & ~ready_sel;

  // A ready only counts once valid has actually been presented; a ready left
  // over from an earlier transaction cannot complete a fresh request.
  assign ack_o       = req_q & ready_sel & seen_q;
  assign timeout_o   = req_q & ~ack_o & (cnt_q == LAST_CNT);
  assign busy_o      = req_q;
  assign line_zero_o = (bus.rd_data[9:0] == 10'd0);
  assign unused_rd_bits = ^bus.rd_data[31:10];

  assign bus.wr_valid  = drive_valid & ~rd_q;
  assign bus.rd_valid  = drive_valid & rd_q;
  assign bus.wr_addr   = addr_q;
  assign bus.rd_addr   = addr_q;
  assign bus.wr_data   = data_q;
  assign bus.wr_byteEn = 4'hF;
  assign bus.rd_byteEn = 4'hF;

  // Request latch and per-request timeout counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_q  <= 1'b0;
      rd_q   <= 1'b0;
      seen_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else if (start_i) begin
      req_q  <= 1'b1;
      rd_q   <= is_rd_i;
      seen_q <= 1'b0;
      addr_q <= addr_i;
      data_q <= data_i;
      cnt_q  <= '0;
    end else if (req_q) begin
      if (ack_o || timeout_o) begin
        req_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 16'd1;
        if (drive_valid) seen_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_fill_engine.sv
// Rectangle fill engine: accepts one clipped rectangle command and paints it
// row by row through the VGA peripheral's X_ADDR / Y_ADDR / DATA registers.
module vga_fill_engine
  import vga_fill_pkg::*;
#(
  parameter logic [31:0] PERIPH_ADDR = 32'h1000_0000,
  parameter int unsigned MAX_W       = 640,
  parameter int unsigned MAX_H       = 480,
  parameter bit          WAIT_VBLANK = 1'b1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [10:0]       cmd_x_i,
  input  logic [9:0]        cmd_y_i,
  input  logic [10:0]       cmd_w_i,
  input  logic [9:0]        cmd_h_i,
  input  logic [23:0]       cmd_color_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  vga_fill_engine_if.master bus
);

  localparam logic [11:0] MAX_W_L = 12'(MAX_W);
  localparam logic [11:0] MAX_H_L = 12'(MAX_H);

  fill_state_e state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [23:0] color_q, color_d;
  logic [11:0] w_eff_q, w_eff_d, col_q, col_d;
  logic [10:0] h_eff_q, h_eff_d, row_q, row_d;
  logic        err_q, err_d;

  logic [11:0] w_clip, h_clip;
  logic        reject;
  logic        req_start, req_rd, req_busy, req_ack, req_timeout, line_zero;
  logic [7:0]  req_off;
  logic [31:0] req_data;
  logic [10:0] y_row;

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE) && (state_q != DONE);
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;

  // Degenerate or fully off-screen rectangles finish without touching the bus.
  assign w_clip = clip_len({1'b0, cmd_x_i}, {1'b0, cmd_w_i}, MAX_W_L);
  assign h_clip = clip_len({2'b0, cmd_y_i}, {2'b0, cmd_h_i}, MAX_H_L);
  assign reject = ({1'b0, cmd_x_i} >= MAX_W_L) || ({2'b0, cmd_y_i} >= MAX_H_L) ||
                  (cmd_w_i == 11'd0) || (cmd_h_i == 10'd0);
  assign y_row  = {1'b0, y_q} + row_q;

  // Register address/data for the transaction belonging to the current state.
  always_comb begin
    req_rd   = 1'b0;
    req_off  = REG_EN;
    req_data = '0;
    case (state_q)
      POLL:    begin req_rd = 1'b1; req_off = REG_SCANLINE; end
      SET_X:   begin req_off = REG_X_ADDR; req_data = {21'd0, x_q}; end
      SET_Y:   begin req_off = REG_Y_ADDR; req_data = {21'd0, y_row}; end
      FILL:    begin req_off = REG_DATA;   req_data = {8'd0, color_q}; end
      default: ;
    endcase
    req_start = (state_q == POLL || state_q == SET_X || state_q == SET_Y || state_q == FILL)
                && !req_busy;
  end

  vga_bus_req #(.TIMEOUT(TIMEOUT)) u_req (
    .clock       (clock),
    .reset       (reset),
    .start_i     (req_start),
    .is_rd_i     (req_rd),
    .addr_i      (PERIPH_ADDR + {24'd0, req_off}),
    .data_i      (req_data),
    .busy_o      (req_busy),
    .ack_o       (req_ack),
    .timeout_o   (req_timeout),
    .line_zero_o (line_zero),
    .bus         (bus)
  );

  // Sequencer: accept, optional blanking poll, then X/Y/DATA per row.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    w_eff_d = w_eff_q;
    h_eff_d = h_eff_q;
    col_d   = col_q;
    row_d   = row_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          x_d     = cmd_x_i;
          y_d     = cmd_y_i;
          color_d = cmd_color_i;
          w_eff_d = w_clip;
          h_eff_d = h_clip[10:0];
          col_d   = '0;
          row_d   = '0;
          err_d   = 1'b0;
          if (reject)           state_d = DONE;
          else if (WAIT_VBLANK) state_d = POLL;
          else                  state_d = SET_X;
        end
      end
      POLL, SET_X, SET_Y, FILL: begin
        if (req_timeout) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (req_ack) begin
          case (state_q)
            POLL:  if (line_zero) state_d = SET_X;
            SET_X: state_d = SET_Y;
            SET_Y: begin state_d = FILL; col_d = '0; end
            FILL: begin
              if (col_q == w_eff_q - 12'd1) begin
                col_d = '0;
                if (row_q == h_eff_q - 11'd1) begin
                  state_d = DONE;
                end else begin
                  row_d   = row_q + 11'd1;
                  state_d = SET_X;
                end
              end else begin
                col_d = col_q + 12'd1;
              end
            end
            default: ;
          endcase
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and command registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      w_eff_q <= '0;
      h_eff_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
      w_eff_q <= w_eff_d;
      h_eff_q <= h_eff_d;
      col_q   <= col_d;
      row_q   <= row_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_vga_fill_engine.sv
// Directed bench for vga_fill_engine: two instances (no blanking poll / with
// blanking poll) share one command bus and a simple worker model each.
module tb_vga_fill_engine;

  localparam logic [31:0] PA = 32'h1000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  cmd_valid = '0;
  logic [10:0] cmd_x = '0;
  logic [9:0]  cmd_y = '0;
  logic [10:0] cmd_w = '0;
  logic [9:0]  cmd_h = '0;
  logic [23:0] cmd_color = '0;
  logic [1:0]  cmd_ready, busy, done, err;
  logic [1:0]  wv, rv;
  logic [31:0] wa [2];
  logic [31:0] wd [2];
  logic [31:0] ra [2];
  logic [3:0]  wbe [2];
  logic [3:0]  rbe [2];

  // Worker model state
  logic [1:0]  rdy_q  = '0;
  logic [1:0]  kind_q = '0;
  int          rem_q [2] = '{0, 0};
  logic [31:0] rdata_q [2] = '{32'd0, 32'd0};
  int          hold_cycles = 1;
  bit          never_ready = 1'b0;
  logic [31:0] scan_vals [4] = '{32'd100, 32'd50, 32'd0, 32'd0};
  int          scan_n   = 3;
  int          scan_idx = 0;
  logic [31:0] scan_next;
  logic [64:0] trace [$];
  logic [64:0] expq [$];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign scan_next = (scan_idx < scan_n) ? scan_vals[scan_idx[1:0]] : 32'd0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      vga_fill_engine_if bus_if ();
      assign wv[gi]  = bus_if.wr_valid;
      assign rv[gi]  = bus_if.rd_valid;
      assign wa[gi]  = bus_if.wr_addr;
      assign wd[gi]  = bus_if.wr_data;
      assign ra[gi]  = bus_if.rd_addr;
      assign wbe[gi] = bus_if.wr_byteEn;
      assign rbe[gi] = bus_if.rd_byteEn;
      assign bus_if.wr_ready = rdy_q[gi] & ~kind_q[gi];
      assign bus_if.rd_ready = rdy_q[gi] & kind_q[gi];
      assign bus_if.rd_data  = rdata_q[gi];

      vga_fill_engine #(
        .PERIPH_ADDR (PA),
        .MAX_W       (640),
        .MAX_H       (480),
        .WAIT_VBLANK (gi == 1),
        .TIMEOUT     (8)
      ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid_i (cmd_valid[gi]),
        .cmd_ready_o (cmd_ready[gi]),
        .cmd_x_i     (cmd_x),
        .cmd_y_i     (cmd_y),
        .cmd_w_i     (cmd_w),
        .cmd_h_i     (cmd_h),
        .cmd_color_i (cmd_color),
        .busy_o      (busy[gi]),
        .done_o      (done[gi]),
        .err_o       (err[gi]),
        .bus         (bus_if)
      );
    end
  endgenerate

  // Worker: captures a request when idle, then shows ready for hold_cycles cycles.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (rdy_q[i]) begin
        if (rem_q[i] == 0) rdy_q[i] <= 1'b0;
        else rem_q[i] <= rem_q[i] - 1;
      end else if (!never_ready && (wv[i] || rv[i])) begin
        rdy_q[i]  <= 1'b1;
        kind_q[i] <= rv[i];
        rem_q[i]  <= hold_cycles - 1;
        if (rv[i]) begin
          rdata_q[i] <= scan_next;
          scan_idx   <= scan_idx + 1;
          trace.push_back({1'b1, ra[i], scan_next});
          $display("[%0t] dut%0d RD addr=%08h data=%08h", $time, i, ra[i], scan_next);
        end else begin
          trace.push_back({1'b0, wa[i], wd[i]});
          $display("[%0t] dut%0d WR addr=%08h data=%08h", $time, i, wa[i], wd[i]);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] wr_e(input logic [7:0] off, input logic [31:0] d);
    return {1'b0, PA + {24'd0, off}, d};
  endfunction

  function automatic logic [64:0] rd_e(input logic [31:0] d);
    return {1'b1, PA + 32'h1C, d};
  endfunction

  task automatic check_trace(input string tag, input int base);
    check({tag, "_len"}, 65'(trace.size() - base), 65'(expq.size()));
    for (int k = 0; k < expq.size(); k++)
      if (base + k < trace.size())
        check($sformatf("%s[%0d]", tag, k), trace[base + k], expq[k]);
    expq.delete();
  endtask

  task automatic issue(input int s, input logic [10:0] x, input logic [9:0] y,
                       input logic [10:0] w, input logic [9:0] h, input logic [23:0] c);
    @(negedge clock);
    check($sformatf("cmd_ready%0d", s), cmd_ready[s], 1'b1);
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
    cmd_valid[s] = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid[s] = 1'b0;
  endtask

  task automatic wait_done(input int s, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clock);
      if (done[s]) seen = 1'b1;
    end
    check({tag, "_done"}, seen, 1'b1);
    @(negedge clock);
    check({tag, "_done_pulse"}, done[s], 1'b0);
    check({tag, "_idle"}, cmd_ready[s], 1'b1);
  endtask

  initial begin
    int base;
    int cnt;
    int xs, ys, ds;
    bit hit;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_cmd_ready", cmd_ready[0], 1'b1);
    check("rst_busy", busy[0], 1'b0);
    check("rst_done", done[0], 1'b0);
    check("rst_err", err[0], 1'b0);
    check("rst_wr_valid", wv[0], 1'b0);
    check("rst_rd_valid", rv[0], 1'b0);
    check("rst_wr_addr", wa[0], 32'd0);
    check("rst_wr_data", wd[0], 32'd0);
    check("rst_wr_be", wbe[0], 4'hF);
    check("rst_rd_be", rbe[0], 4'hF);
    reset = 1'b0;

    // 1: 3x2 rectangle at (10,20), colour 5, no blanking poll
    base = trace.size();
    issue(0, 11'd10, 10'd20, 11'd3, 10'd2, 24'd5);
    check("t1_busy", busy[0], 1'b1);
    wait_done(0, "t1");
    check("t1_err", err[0], 1'b0);
    expq.push_back(wr_e(8'h04, 32'd10));
    expq.push_back(wr_e(8'h08, 32'd20));
    repeat (3) expq.push_back(wr_e(8'h0C, 32'd5));
    expq.push_back(wr_e(8'h04, 32'd10));
    expq.push_back(wr_e(8'h08, 32'd21));
    repeat (3) expq.push_back(wr_e(8'h0C, 32'd5));
    check_trace("t1", base);

    // 2: blanking poll sees 100, 50, 0 before the first X write
    base = trace.size();
    issue(1, 11'd0, 10'd0, 11'd1, 10'd1, 24'd7);
    wait_done(1, "t2");
    expq.push_back(rd_e(32'd100));
    expq.push_back(rd_e(32'd50));
    expq.push_back(rd_e(32'd0));
    expq.push_back(wr_e(8'h04, 32'd0));
    expq.push_back(wr_e(8'h08, 32'd0));
    expq.push_back(wr_e(8'h0C, 32'd7));
    check_trace("t2", base);

    // 3a: x=638 w=10 clips to two pixels
    base = trace.size();
    issue(0, 11'd638, 10'd5, 11'd10, 10'd1, 24'd9);
    wait_done(0, "t3a");
    expq.push_back(wr_e(8'h04, 32'd638));
    expq.push_back(wr_e(8'h08, 32'd5));
    repeat (2) expq.push_back(wr_e(8'h0C, 32'd9));
    check_trace("t3a", base);

    // 3b: x=640 is off-screen: done the cycle after accept, no traffic
    base = trace.size();
    issue(0, 11'd640, 10'd0, 11'd4, 10'd4, 24'd1);
    @(negedge clock);
    check("t3b_done", done[0], 1'b1);
    check("t3b_busy", busy[0], 1'b0);
    repeat (4) @(negedge clock);
    check_trace("t3b", base);

    // 3c: w=0 is degenerate
    base = trace.size();
    issue(0, 11'd3, 10'd3, 11'd0, 10'd2, 24'd1);
    @(negedge clock);
    check("t3c_done", done[0], 1'b1);
    repeat (4) @(negedge clock);
    check_trace("t3c", base);

    // 3d: y=478 h=5 clips to two rows
    base = trace.size();
    issue(0, 11'd0, 10'd478, 11'd1, 10'd5, 24'd3);
    wait_done(0, "t3d");
    expq.push_back(wr_e(8'h04, 32'd0));
    expq.push_back(wr_e(8'h08, 32'd478));
    expq.push_back(wr_e(8'h0C, 32'd3));
    expq.push_back(wr_e(8'h04, 32'd0));
    expq.push_back(wr_e(8'h08, 32'd479));
    expq.push_back(wr_e(8'h0C, 32'd3));
    check_trace("t3d", base);

    // 4: worker never answers -> valid for 8 cycles, err set, done pulses
    never_ready = 1'b1;
    issue(0, 11'd1, 10'd1, 11'd1, 10'd1, 24'd2);
    cnt = 0;
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clock);
      if (wv[0]) cnt++;
      if (done[0]) hit = 1'b1;
    end
    check("t4_done", hit, 1'b1);
    check("t4_valid_cycles", 65'(cnt), 65'd8);
    check("t4_err_at_done", err[0], 1'b1);
    @(negedge clock);
    check("t4_err_sticky", err[0], 1'b1);
    check("t4_valid_low", wv[0], 1'b0);
    never_ready = 1'b0;
    base = trace.size();
    issue(0, 11'd2, 10'd2, 11'd1, 10'd1, 24'd3);
    check("t4_err_cleared", err[0], 1'b0);
    wait_done(0, "t4b");
    check("t4b_err", err[0], 1'b0);
    expq.push_back(wr_e(8'h04, 32'd2));
    expq.push_back(wr_e(8'h08, 32'd2));
    expq.push_back(wr_e(8'h0C, 32'd3));
    check_trace("t4b", base);

    // 5: ready held two cycles -> no duplicated writes (4x3 at (100,200))
    hold_cycles = 2;
    base = trace.size();
    issue(0, 11'd100, 10'd200, 11'd4, 10'd3, 24'd6);
    wait_done(0, "t5");
    repeat (2) @(negedge clock);
    xs = 0; ys = 0; ds = 0;
    for (int k = base; k < trace.size(); k++) begin
      if (trace[k][63:32] == PA + 32'h04) xs++;
      if (trace[k][63:32] == PA + 32'h08) ys++;
      if (trace[k][63:32] == PA + 32'h0C) ds++;
    end
    check("t5_total", 65'(trace.size() - base), 65'd18);
    check("t5_x_writes", 65'(xs), 65'd3);
    check("t5_y_writes", 65'(ys), 65'd3);
    check("t5_data_writes", 65'(ds), 65'd12);
    check("t5_last_y", trace[trace.size() - 5], wr_e(8'h08, 32'd202));
    hold_cycles = 1;

    // 6: reset during FILL drops valid at once; a new command then runs normally
    base = trace.size();
    issue(0, 11'd0, 10'd0, 11'd50, 10'd2, 24'd1);
    hit = 1'b0;
    for (int k = 0; k < 500 && !hit; k++) begin
      @(negedge clock);
      if (trace.size() - base >= 5 && wv[0]) hit = 1'b1;
    end
    check("t6_in_fill", hit, 1'b1);
    reset = 1'b1;
    #1;
    check("t6_rst_valid", wv[0], 1'b0);
    check("t6_rst_busy", busy[0], 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("t6_ready_after", cmd_ready[0], 1'b1);
    check("t6_valid_after", wv[0], 1'b0);
    base = trace.size();
    issue(0, 11'd5, 10'd6, 11'd2, 10'd1, 24'd4);
    wait_done(0, "t6b");
    expq.push_back(wr_e(8'h04, 32'd5));
    expq.push_back(wr_e(8'h08, 32'd6));
    repeat (2) expq.push_back(wr_e(8'h0C, 32'd4));
    check_trace("t6b", base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
